// File: rtl/mmio_axil_master_if.sv
// AXI4-Lite bus bundle between the MMIO master and a slave.
// master modport: drives AW/W/AR address, data and VALIDs plus BREADY/RREADY;
//                 receives AWREADY, WREADY, ARREADY, B and R channel signals.
// slave modport : the mirror image.
interface mmio_axil_master_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned RESP_W = 2;

  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [RESP_W-1:0] BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [RESP_W-1:0] RRESP;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/mmio_axil_master.sv
// Single-outstanding MMIO request -> AXI4-Lite master bridge.
// Ports:
//   ACLK, ARESETn        clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake; req_addr, req_wdata, req_write payload
//   rsp_valid            one-cycle response pulse with rsp_rdata, rsp_resp, rsp_timeout
//   axi                  AXI4-Lite master side (AW, W, B, AR, R channels)
// A per-phase watchdog (TIMEOUT_CYC, 0 = off) aborts a stalled transaction and
// reports it with rsp_timeout=1 and SLVERR.
module mmio_axil_master #(
  parameter int unsigned TIMEOUT_CYC    = 1000,
  parameter logic [31:0] ADDR_BASE_MASK = 32'hFFFF_FFFF
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_write,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_resp,
  output logic        rsp_timeout,
  mmio_axil_master_if.master axi
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned RESP_W = 2;
  localparam int unsigned CNT_W  = 32;
  localparam logic [RESP_W-1:0] RESP_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WB,
    S_RA,
    S_RD,
    S_RSP
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [RESP_W-1:0] rsp_resp_q, rsp_resp_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [CNT_W-1:0]  cnt_inc;
  logic              timeout_hit;

  assign aw_hs = awvalid_q & axi.AWREADY;
  assign w_hs  = wvalid_q  & axi.WREADY;
  assign b_hs  = bready_q  & axi.BVALID;
  assign ar_hs = arvalid_q & axi.ARREADY;
  assign r_hs  = rready_q  & axi.RVALID;

  // Watchdog fires when this cycle would make the idle-wait count reach the limit.
  assign cnt_inc     = cnt_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_inc == CNT_W'(TIMEOUT_CYC));

  // State and datapath registers.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      req_ready_q   <= req_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      cnt_q         <= cnt_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    logic do_abort;
    do_abort      = 1'b0;
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    cnt_d         = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d        = req_addr & ADDR_BASE_MASK;
          wdata_d       = req_wdata;
          cnt_d         = '0;
          rsp_rdata_d   = '0;
          rsp_resp_d    = '0;
          rsp_timeout_d = 1'b0;
          if (req_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
            state_d   = S_WR;
          end else begin
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
            state_d   = S_RA;
          end
        end
      end

      // AW and W retire independently; BREADY is already up.
      S_WR: begin
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (aw_hs || w_hs) begin
          cnt_d = '0;
          if (!awvalid_d && !wvalid_d) state_d = S_WB;
        end else if (timeout_hit) begin
          do_abort = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_WB: begin
        if (b_hs) begin
          bready_d    = 1'b0;
          rsp_resp_d  = axi.BRESP;
          rsp_rdata_d = '0;
          cnt_d       = '0;
          state_d     = S_RSP;
        end else if (timeout_hit) begin
          do_abort = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_RA: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_RD;
        end else if (timeout_hit) begin
          do_abort = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_RD: begin
        if (r_hs) begin
          rready_d    = 1'b0;
          rsp_rdata_d = axi.RDATA;
          rsp_resp_d  = axi.RRESP;
          cnt_d       = '0;
          state_d     = S_RSP;
        end else if (timeout_hit) begin
          do_abort = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      S_RSP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abandon the bus transaction and report a timeout.
    if (do_abort) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_rdata_d   = '0;
      rsp_resp_d    = RESP_TIMEOUT;
      rsp_timeout_d = 1'b1;
      cnt_d         = '0;
      state_d       = S_RSP;
    end

    req_ready_d = (state_d == S_IDLE);
    rsp_valid_d = (state_d == S_RSP);
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;

  assign axi.AWADDR  = addr_q;
  assign axi.AWVALID = awvalid_q;
  assign axi.WDATA   = wdata_q;
  assign axi.WSTRB   = 4'hF;
  assign axi.WVALID  = wvalid_q;
  assign axi.BREADY  = bready_q;
  assign axi.ARADDR  = addr_q;
  assign axi.ARVALID = arvalid_q;
  assign axi.RREADY  = rready_q;

endmodule

// File: tb/tb_mmio_axil_master.sv
// Bench for mmio_axil_master: a two-register GPIO slave with per-transaction
// ready/response delays, a reference model of register contents and response
// rules, and a negedge monitor that pops expected responses from a scoreboard.
module tb_mmio_axil_master;
  localparam int unsigned TO    = 16;
  localparam int          NEVER = 1000;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_write = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;

  always #5 ACLK = ~ACLK;

  mmio_axil_master_if bus();

  mmio_axil_master #(.TIMEOUT_CYC(TO), .ADDR_BASE_MASK(32'hFFFF_FFFF)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_write(req_write),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout), .axi(bus)
  );

  int checks = 0;
  int errors = 0;
  int rsp_seen = 0;
  int cyc = 0;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } exp_t;
  exp_t exp_q[$];

  logic [31:0] model [2] = '{32'h0, 32'h0};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, expv, $time);
    end
  endtask

  function automatic logic addr_ok(input logic [31:0] a);
    return (a[31:3] == 29'd0) && (a[1:0] == 2'd0);
  endfunction

  // ---------------- GPIO slave ----------------
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic slave_flush = 1'b0;
  logic [31:0] slv_mem [2] = '{32'h0, 32'h0};
  logic aw_got = 0, w_got = 0, b_pend = 0, ar_got = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  int aw_cyc = 0, w_cyc = 0;
  logic [31:0] aw_a = '0, w_d = '0, ar_a = '0;
  logic [1:0]  b_resp = '0;

  assign bus.AWREADY = bus.AWVALID && !aw_got && (aw_cnt >= aw_dly);
  assign bus.WREADY  = bus.WVALID && !w_got && (w_cnt >= w_dly);
  assign bus.BVALID  = b_pend && (b_cnt >= b_dly);
  assign bus.BRESP   = b_resp;
  assign bus.ARREADY = bus.ARVALID && !ar_got && (ar_cnt >= ar_dly);
  assign bus.RVALID  = ar_got && (r_cnt >= r_dly);
  assign bus.RDATA   = addr_ok(ar_a) ? slv_mem[ar_a[2]] : 32'hDEADBEEF;
  assign bus.RRESP   = addr_ok(ar_a) ? 2'b00 : 2'b11;

  always @(posedge ACLK) begin
    cyc <= cyc + 1;
    if (slave_flush) begin
      aw_got <= 0; w_got <= 0; b_pend <= 0; ar_got <= 0;
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
    end else begin
      if (bus.AWVALID && !aw_got) begin
        if (bus.AWREADY) begin aw_got <= 1; aw_a <= bus.AWADDR; aw_cyc <= cyc; end
        else aw_cnt <= aw_cnt + 1;
      end else aw_cnt <= 0;
      if (bus.WVALID && !w_got) begin
        if (bus.WREADY) begin w_got <= 1; w_d <= bus.WDATA; w_cyc <= cyc; end
        else w_cnt <= w_cnt + 1;
      end else w_cnt <= 0;
      if (aw_got && w_got && !b_pend) begin
        b_pend <= 1; b_cnt <= 0; aw_got <= 0; w_got <= 0;
        if (addr_ok(aw_a)) begin slv_mem[aw_a[2]] <= w_d; b_resp <= 2'b00; end
        else b_resp <= 2'b11;
      end
      if (b_pend) begin
        if (bus.BVALID && bus.BREADY) b_pend <= 0;
        else b_cnt <= b_cnt + 1;
      end
      if (bus.ARVALID && !ar_got) begin
        if (bus.ARREADY) begin ar_got <= 1; ar_a <= bus.ARADDR; r_cnt <= 0; end
        else ar_cnt <= ar_cnt + 1;
      end else ar_cnt <= 0;
      if (ar_got) begin
        if (bus.RVALID && bus.RREADY) ar_got <= 0;
        else r_cnt <= r_cnt + 1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic p_ok, p_rv, p_reqv, p_reqr, p_reqw;
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr;
    logic [31:0] p_awa, p_wd, p_ara;
    exp_t e;
    p_ok = 0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        p_ok = 0;
      end else begin
        if (rsp_valid) begin
          rsp_seen++;
          if (p_ok && p_rv) begin
            checks++; errors++;
            $display("FAIL rsp_double rsp_valid high two cycles t=%0t", $time);
          end
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL rsp_unexpected rdata=%h resp=%b t=%0t", rsp_rdata, rsp_resp, $time);
          end else begin
            e = exp_q.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_resp", 32'(rsp_resp), 32'(e.resp));
            chk("rsp_timeout", 32'(rsp_timeout), 32'(e.to));
          end
        end
        if (p_ok) begin
          if (p_reqv && p_reqr) begin
            if (p_reqw) chk("aw_w_bready_after_accept", {bus.AWVALID, bus.WVALID, bus.BREADY}, 3'b111);
            else        chk("ar_rready_after_accept", {bus.ARVALID, bus.RREADY}, 2'b11);
          end
          if (p_awv && p_awr) chk("awvalid_drop", bus.AWVALID, 0);
          if (p_wv && p_wr)   chk("wvalid_drop", bus.WVALID, 0);
          if (p_arv && p_arr) chk("arvalid_drop", bus.ARVALID, 0);
          if (p_awv && !p_awr && bus.AWVALID) chk("awaddr_stable", bus.AWADDR, p_awa);
          if (p_wv && !p_wr && bus.WVALID)    chk("wdata_stable", bus.WDATA, p_wd);
          if (p_arv && !p_arr && bus.ARVALID) chk("araddr_stable", bus.ARADDR, p_ara);
          if (bus.WVALID && !p_wv) chk("wstrb", 32'(bus.WSTRB), 32'hF);
        end
        p_rv = rsp_valid; p_reqv = req_valid; p_reqr = req_ready; p_reqw = req_write;
        p_awv = bus.AWVALID; p_awr = bus.AWREADY; p_awa = bus.AWADDR;
        p_wv = bus.WVALID; p_wr = bus.WREADY; p_wd = bus.WDATA;
        p_arv = bus.ARVALID; p_arr = bus.ARREADY; p_ara = bus.ARADDR;
        p_ok = 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic set_knobs(input int a, input int w, input int b, input int ar, input int r);
    aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  task automatic flush_slave();
    @(posedge ACLK); #1 slave_flush = 1'b1;
    @(posedge ACLK); #1 slave_flush = 1'b0;
  endtask

  task automatic accept(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        output logic ok);
    int n;
    req_write = wr; req_addr = addr; req_wdata = data; req_valid = 1'b1;
    n = 0;
    @(negedge ACLK);
    while (!req_ready && n < 50) begin @(negedge ACLK); n++; end
    ok = req_ready;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL req_accept req_ready stayed low t=%0t", $time);
      req_valid = 1'b0;
    end else begin
      @(posedge ACLK); #1 req_valid = 1'b0;
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                       output int lat);
    exp_t e;
    logic ok, nev, commit;
    int start;
    lat = 0;
    if (wr) begin
      commit = (aw_dly < NEVER) && (w_dly < NEVER);
      nev    = !commit || (b_dly >= NEVER);
      if (commit && addr_ok(addr)) model[addr[2]] = data;
      e.rdata = '0;
      e.resp  = nev ? 2'b10 : (addr_ok(addr) ? 2'b00 : 2'b11);
      e.to    = nev;
    end else begin
      nev     = (ar_dly >= NEVER) || (r_dly >= NEVER);
      e.rdata = nev ? 32'h0 : (addr_ok(addr) ? model[addr[2]] : 32'hDEADBEEF);
      e.resp  = nev ? 2'b10 : (addr_ok(addr) ? 2'b00 : 2'b11);
      e.to    = nev;
    end
    exp_q.push_back(e);
    start = rsp_seen;
    accept(wr, addr, data, ok);
    if (!ok) begin
      void'(exp_q.pop_back());
    end else begin
      while (rsp_seen == start && lat < 80) begin @(negedge ACLK); lat++; end
      chk("rsp_count", rsp_seen, start + 1);
      if (rsp_seen == start) void'(exp_q.pop_front());
      flush_slave();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, seen0, n;
    logic ok;
    logic [31:0] addrs [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100};

    // Reset values while held in reset.
    repeat (3) @(negedge ACLK);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_resp", 32'(rsp_resp), 0);
    chk("rst_valids", {bus.AWVALID, bus.WVALID, bus.ARVALID, bus.BREADY, bus.RREADY}, 0);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    chk("req_ready_after_release", req_ready, 1);

    // Write then read back, plus a decode error read.
    set_knobs(0, 0, 0, 0, 0);
    issue(1'b1, 32'h0, 32'hA5A5_0001, lat);
    chk("aw_w_same_cycle", 32'(aw_cyc - w_cyc), 0);
    chk("slave_reg0", slv_mem[0], 32'hA5A5_0001);
    issue(1'b0, 32'h0, 32'h0, lat);
    issue(1'b0, 32'h8, 32'h0, lat);

    // AWREADY held off three cycles, WREADY immediate.
    set_knobs(3, 0, 1, 0, 0);
    issue(1'b1, 32'h4, 32'h1357_9BDF, lat);
    chk("aw_after_w_by_3", 32'(aw_cyc - w_cyc), 3);

    // ARREADY never comes: watchdog, then a normal write.
    set_knobs(0, 0, 0, NEVER, 0);
    issue(1'b0, 32'h0, 32'h0, lat);
    chk("timeout_latency_le_18", 32'(lat <= 18), 1);
    set_knobs(0, 0, 0, 0, 0);
    issue(1'b1, 32'h4, 32'h0BAD_F00D, lat);

    // Reset while waiting for B; the late B must be ignored.
    set_knobs(0, 0, 10, 0, 0);
    seen0 = rsp_seen;
    model[1] = 32'h1234_5678;
    accept(1'b1, 32'h4, 32'h1234_5678, ok);
    n = 0;
    while (!(!bus.AWVALID && !bus.WVALID && bus.BREADY) && n < 20) begin @(negedge ACLK); n++; end
    chk("reached_wb", {bus.AWVALID, bus.WVALID, bus.BREADY}, 3'b001);
    #1 ARESETn = 1'b0;
    #1;
    chk("abort_outputs", {bus.AWVALID, bus.WVALID, bus.BREADY, bus.ARVALID, bus.RREADY}, 0);
    chk("abort_req_ready", req_ready, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    @(posedge ACLK); #1;
    chk("req_ready_after_abort", req_ready, 1);
    repeat (15) @(negedge ACLK);
    chk("late_b_bready_low", bus.BREADY, 0);
    chk("late_b_no_rsp", rsp_seen, seen0);
    flush_slave();
    set_knobs(0, 0, 0, 0, 0);
    issue(1'b0, 32'h4, 32'h0, lat);

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      logic wr;
      int pick;
      wr = 1'($urandom_range(0, 1));
      set_knobs(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
      if ($urandom_range(0, 7) == 0) begin
        pick = int'($urandom_range(0, 2));
        if (wr) begin
          if (pick == 0) aw_dly = NEVER; else if (pick == 1) w_dly = NEVER; else b_dly = NEVER;
        end else begin
          if (pick == 0) ar_dly = NEVER; else r_dly = NEVER;
        end
      end
      issue(wr, addrs[$urandom_range(0, 4)], $urandom, lat);
    end

    repeat (5) @(negedge ACLK);
    chk("scoreboard_empty", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
